velocity_write_arbiter: RTL and testbench

Arbitrates ball-velocity write requests from the cue-line (shot) source and the collision-hit source onto the single velocity write port of the ball velocity registers. Each source gets its own request FIFO with a valid/ready handshake. A fixed-priority grant with an anti-starvation counter selects which request is written. All writes are held off while the physics update holds the lock. Sits between the shot/collision logic and the per-ball velocity registers.

---
 rtl/velocity_arb_pkg.sv | 41 ++++
 rtl/vel_req_fifo.sv | 87 ++++++++
 rtl/velocity_write_arbiter.sv | 177 +++++++++++++++++
 tb/tb_velocity_write_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/velocity_arb_pkg.sv
// Shared types, limits and saturation helpers for the ball-velocity write arbiter.
package velocity_arb_pkg;

    localparam int VEL_W         = 11;
    localparam int DEF_BALL_ID_W = 4;
    localparam int MAX_SPEED     = 511;

    typedef logic signed [VEL_W-1:0] velocity_t;

    typedef struct packed {
        logic [DEF_BALL_ID_W-1:0] ballId;
        velocity_t                vx;
        velocity_t                vy;
    } vel_req_t;

    typedef enum logic {
        SRC_LINE = 1'b0,
        SRC_HIT  = 1'b1
    } vel_src_t;

    localparam velocity_t VEL_MAX = velocity_t'(MAX_SPEED);
    localparam velocity_t VEL_MIN = velocity_t'(-MAX_SPEED);

    function automatic logic vel_out_of_range(input velocity_t v);
        return (v > VEL_MAX) || (v < VEL_MIN);
    endfunction

    // -1024 has no positive counterpart, so it lands on VEL_MIN like any other low value.
    function automatic velocity_t clamp_vel(input velocity_t v);
        velocity_t r;
        if (v > VEL_MAX) begin
            r = VEL_MAX;
        end else if (v < VEL_MIN) begin
            r = VEL_MIN;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/vel_req_fifo.sv
// Synchronous request FIFO with registered full flag; one instance per velocity source.
module vel_req_fifo
    import velocity_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = $bits(vel_req_t)
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             do_push_s, do_pop_s;

    assign do_push_s  = push_i && !full_q;
    assign do_pop_s   = pop_i && (count_q != CNT_ZERO);
    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = (count_q == CNT_ZERO);

    // Pointer and occupancy next-state; pointers wrap because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d = (count_d == CNT_FULL);
    end

    // Pointer, occupancy and full-flag registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= CNT_ZERO;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/velocity_write_arbiter.sv
// Arbitrates line (shot) and hit (collision) velocity writes onto one register write port.
// Optional clamping to +/-MAX_SPEED is enabled by defining VELOCITY_ARB_SATURATE_EN.
module velocity_write_arbiter
    import velocity_arb_pkg::*;
#(
    parameter int BALL_ID_W    = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 lineValid,
    output logic                 lineReady,
    input  logic [BALL_ID_W-1:0] lineBallId,
    input  logic signed [10:0]   lineVelocityX,
    input  logic signed [10:0]   lineVelocityY,
    input  logic                 hitValid,
    output logic                 hitReady,
    input  logic [BALL_ID_W-1:0] hitBallId,
    input  logic signed [10:0]   hitVelocityX,
    input  logic signed [10:0]   hitVelocityY,
    input  logic                 updateLock,
    output logic                 writeEnable,
    output logic [BALL_ID_W-1:0] writeBallId,
    output logic signed [10:0]   outVelocityX,
    output logic signed [10:0]   outVelocityY,
    output logic                 writeSrcHit,
    output logic                 writeSat
);

    // Same layout as vel_req_t, but the ball index follows this instance's BALL_ID_W.
    typedef struct packed {
        logic [BALL_ID_W-1:0] ballId;
        velocity_t            vx;
        velocity_t            vy;
    } req_t;

    localparam int              REQ_W      = $bits(req_t);
    localparam int              SC_W       = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [SC_W-1:0] SC_ONE     = SC_W'(1);
    localparam logic [SC_W-1:0] SC_ZERO    = SC_W'(0);

    req_t             line_wr_s, hit_wr_s;
    req_t             line_rd_s, hit_rd_s, sel_req_s;
    logic [REQ_W-1:0] line_rd_vec_s, hit_rd_vec_s;
    logic             line_full_s, line_empty_s, line_push_s;
    logic             hit_full_s, hit_empty_s, hit_push_s;
    logic             pop_line_s, pop_hit_s, pop_any_s;
    vel_src_t         grant_src_s;
    velocity_t        sel_vx_s, sel_vy_s;
    logic             sel_sat_s;
    logic [SC_W-1:0]  starve_q, starve_d;

    logic                 write_en_q;
    logic [BALL_ID_W-1:0] ball_id_q;
    velocity_t            vel_x_q, vel_y_q;
    logic                 src_hit_q;
    logic                 sat_q;

    assign line_wr_s   = '{ballId: lineBallId, vx: lineVelocityX, vy: lineVelocityY};
    assign hit_wr_s    = '{ballId: hitBallId, vx: hitVelocityX, vy: hitVelocityY};
    assign line_push_s = lineValid && !line_full_s;
    assign hit_push_s  = hitValid && !hit_full_s;
    assign lineReady   = !line_full_s;
    assign hitReady    = !hit_full_s;
    assign line_rd_s   = line_rd_vec_s;
    assign hit_rd_s    = hit_rd_vec_s;
    assign pop_any_s   = pop_line_s || pop_hit_s;

    vel_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_line_fifo (
        .clk         (clk),
        .resetN      (resetN),
        .push_i      (line_push_s),
        .push_data_i (line_wr_s),
        .pop_i       (pop_line_s),
        .pop_data_o  (line_rd_vec_s),
        .full_o      (line_full_s),
        .empty_o     (line_empty_s)
    );

    vel_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_hit_fifo (
        .clk         (clk),
        .resetN      (resetN),
        .push_i      (hit_push_s),
        .push_data_i (hit_wr_s),
        .pop_i       (pop_hit_s),
        .pop_data_o  (hit_rd_vec_s),
        .full_o      (hit_full_s),
        .empty_o     (hit_empty_s)
    );

    // Grant: line has priority unless hit has waited STARVE_LIMIT line grants.
    always_comb begin
        pop_line_s  = 1'b0;
        pop_hit_s   = 1'b0;
        grant_src_s = SRC_LINE;
        if (updateLock || (line_empty_s && hit_empty_s)) begin
            pop_line_s = 1'b0;
            pop_hit_s  = 1'b0;
        end else if (!line_empty_s && !(!hit_empty_s && (starve_q == STARVE_MAX))) begin
            pop_line_s = 1'b1;
        end else begin
            pop_hit_s   = 1'b1;
            grant_src_s = SRC_HIT;
        end
    end

    // Starvation counter: counts line grants taken over a waiting hit request.
    always_comb begin
        starve_d = starve_q;
        if (hit_empty_s || pop_hit_s) begin
            starve_d = SC_ZERO;
        end else if (pop_line_s && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SC_ONE;
        end else begin
            starve_d = starve_q;
        end
    end

    // Data of the granted source.
    always_comb begin
        sel_req_s = line_rd_s;
        if (grant_src_s == SRC_HIT) begin
            sel_req_s = hit_rd_s;
        end else begin
            sel_req_s = line_rd_s;
        end
    end

`ifdef VELOCITY_ARB_SATURATE_EN
    assign sel_vx_s  = clamp_vel(sel_req_s.vx);
    assign sel_vy_s  = clamp_vel(sel_req_s.vy);
    assign sel_sat_s = vel_out_of_range(sel_req_s.vx) || vel_out_of_range(sel_req_s.vy);
`else
    assign sel_vx_s  = sel_req_s.vx;
    assign sel_vy_s  = sel_req_s.vy;
    assign sel_sat_s = 1'b0;
`endif

    // Output registers load on a pop and hold until the next one; strobe lasts one cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            starve_q   <= SC_ZERO;
            write_en_q <= 1'b0;
            ball_id_q  <= {BALL_ID_W{1'b0}};
            vel_x_q    <= 11'sd0;
            vel_y_q    <= 11'sd0;
            src_hit_q  <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            write_en_q <= pop_any_s;
            if (pop_any_s) begin
                ball_id_q <= sel_req_s.ballId;
                vel_x_q   <= sel_vx_s;
                vel_y_q   <= sel_vy_s;
                src_hit_q <= (grant_src_s == SRC_HIT);
                sat_q     <= sel_sat_s;
            end
        end
    end

    assign writeEnable  = write_en_q;
    assign writeBallId  = ball_id_q;
    assign outVelocityX = vel_x_q;
    assign outVelocityY = vel_y_q;
    assign writeSrcHit  = src_hit_q;
    assign writeSat     = sat_q;

endmodule

// File: tb/tb_velocity_write_arbiter.sv
// Self-checking bench for velocity_write_arbiter: queue-based reference model plus directed cases.
module tb_velocity_write_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic               clk, resetN, updateLock;
    logic               lineValid, lineReady, hitValid, hitReady;
    logic [3:0]         lineBallId, hitBallId, writeBallId;
    logic signed [10:0] lineVelocityX, lineVelocityY, hitVelocityX, hitVelocityY;
    logic signed [10:0] outVelocityX, outVelocityY;
    logic               writeEnable, writeSrcHit, writeSat;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    typedef struct { int id; int vx; int vy; } req_t;
    req_t line_q[$];
    req_t hit_q[$];
    int   starve;
    int   exp_we, exp_id, exp_vx, exp_vy, exp_src, exp_sat;

    velocity_write_arbiter #(
        .BALL_ID_W    (4),
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .lineValid     (lineValid),
        .lineReady     (lineReady),
        .lineBallId    (lineBallId),
        .lineVelocityX (lineVelocityX),
        .lineVelocityY (lineVelocityY),
        .hitValid      (hitValid),
        .hitReady      (hitReady),
        .hitBallId     (hitBallId),
        .hitVelocityX  (hitVelocityX),
        .hitVelocityY  (hitVelocityY),
        .updateLock    (updateLock),
        .writeEnable   (writeEnable),
        .writeBallId   (writeBallId),
        .outVelocityX  (outVelocityX),
        .outVelocityY  (outVelocityY),
        .writeSrcHit   (writeSrcHit),
        .writeSat      (writeSat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int sat_val(input int v);
`ifdef VELOCITY_ARB_SATURATE_EN
        if (v > 511) return 511;
        if (v < -511) return -511;
`endif
        return v;
    endfunction

    function automatic int sat_flag(input int v);
`ifdef VELOCITY_ARB_SATURATE_EN
        return (v > 511 || v < -511) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        line_q.delete();
        hit_q.delete();
        starve = 0;
        exp_we = 0; exp_id = 0; exp_vx = 0; exp_vy = 0; exp_src = 0; exp_sat = 0;
    endtask

    // One clock edge of the reference behaviour, using the queue contents before the edge.
    task automatic model_step();
        bit l_acc, h_acc, pl, ph;
        req_t r;
        l_acc = lineValid && (line_q.size() < DEPTH);
        h_acc = hitValid && (hit_q.size() < DEPTH);
        pl = 0;
        ph = 0;
        if (!updateLock && (line_q.size() + hit_q.size()) > 0) begin
            if (line_q.size() > 0 && !(hit_q.size() > 0 && starve == LIMIT)) pl = 1;
            else ph = 1;
        end
        if (hit_q.size() == 0 || ph) starve = 0;
        else if (pl && starve < LIMIT) starve++;
        exp_we = (pl || ph) ? 1 : 0;
        if (pl || ph) begin
            if (pl) r = line_q.pop_front();
            else r = hit_q.pop_front();
            exp_id  = r.id;
            exp_vx  = sat_val(r.vx);
            exp_vy  = sat_val(r.vy);
            exp_src = ph ? 1 : 0;
            exp_sat = sat_flag(r.vx) | sat_flag(r.vy);
        end
        if (l_acc) line_q.push_back('{int'(lineBallId), int'(lineVelocityX), int'(lineVelocityY)});
        if (h_acc) hit_q.push_back('{int'(hitBallId), int'(hitVelocityX), int'(hitVelocityY)});
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_we", writeEnable, exp_we);
            chk("cmp_ball", writeBallId, exp_id);
            chk("cmp_vx", outVelocityX, exp_vx);
            chk("cmp_vy", outVelocityY, exp_vy);
            chk("cmp_src", writeSrcHit, exp_src);
            chk("cmp_sat", writeSat, exp_sat);
            chk("cmp_line_ready", lineReady, (line_q.size() != DEPTH) ? 1 : 0);
            chk("cmp_hit_ready", hitReady, (hit_q.size() != DEPTH) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        if (resetN) model_step();
        else model_reset();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        lineValid = 1'b0;
        hitValid = 1'b0;
        updateLock = 1'b0;
    endtask

    // Called at a falling edge; asserts reset off-edge and releases it one cycle later.
    task automatic pulse_reset(input string name);
        #2 resetN = 1'b0;
        model_reset();
        #1;
        chk({name, "_we"}, writeEnable, 0);
        chk({name, "_ball"}, writeBallId, 0);
        chk({name, "_vx"}, outVelocityX, 0);
        chk({name, "_vy"}, outVelocityY, 0);
        chk({name, "_src"}, writeSrcHit, 0);
        chk({name, "_sat"}, writeSat, 0);
        chk({name, "_line_ready"}, lineReady, 1);
        chk({name, "_hit_ready"}, hitReady, 1);
        idle_inputs();
        @(negedge clk);
        #2 resetN = 1'b1;
    endtask

    task automatic rand_inputs(input int lock_pct);
        updateLock = ($urandom_range(0, 99) < lock_pct);
        if (!(lineValid && !lineReady)) begin
            lineValid = 1'($urandom_range(0, 1));
            lineBallId = 4'($urandom_range(0, 15));
            lineVelocityX = 11'($urandom);
            lineVelocityY = 11'($urandom);
        end
        if (!(hitValid && !hitReady)) begin
            hitValid = 1'($urandom_range(0, 1));
            hitBallId = 4'($urandom_range(0, 15));
            hitVelocityX = 11'($urandom);
            hitVelocityY = 11'($urandom);
        end
    endtask

    task automatic measure_starve(input string name);
        int nline;
        bit got_hit;
        nline = 0;
        got_hit = 0;
        hitValid = 1'b1;
        hitBallId = 4'd9;
        hitVelocityX = 11'sd5;
        hitVelocityY = 11'sd6;
        lineValid = 1'b1;
        for (int i = 0; i < 12 && !got_hit; i++) begin
            lineBallId = 4'(i);
            lineVelocityX = 11'(i * 3);
            lineVelocityY = 11'(-i);
            tick();
            if (i == 0) hitValid = 1'b0;
            if (writeEnable) begin
                if (writeSrcHit) got_hit = 1;
                else nline++;
            end
        end
        chk({name, "_hit_granted"}, got_hit, 1);
        chk({name, "_line_writes"}, nline, 3);
        idle_inputs();
        repeat (6) tick();
    endtask

    initial begin
        int n, nw;
        bit acc;
        resetN = 1'b1;
        idle_inputs();
        lineBallId = 4'd0; lineVelocityX = 11'sd0; lineVelocityY = 11'sd0;
        hitBallId = 4'd0; hitVelocityX = 11'sd0; hitVelocityY = 11'sd0;
        model_reset();
        pulse_reset("reset");
        cmp_en = 1'b1;
        tick();
        chk("post_reset_line_ready", lineReady, 1);
        chk("post_reset_hit_ready", hitReady, 1);

        // Single line request: strobe one edge after the accepting edge.
        lineValid = 1'b1; lineBallId = 4'd3; lineVelocityX = 11'sd100; lineVelocityY = -11'sd50;
        tick();
        lineValid = 1'b0;
        chk("t1_no_write_yet", writeEnable, 0);
        tick();
        chk("t1_we", writeEnable, 1);
        chk("t1_ball", writeBallId, 3);
        chk("t1_vx", outVelocityX, 100);
        chk("t1_vy", outVelocityY, -50);
        chk("t1_src", writeSrcHit, 0);
        tick();
        chk("t1_we_drop", writeEnable, 0);
        chk("t1_vx_hold", outVelocityX, 100);

        // Line and hit accepted together: line first, then hit.
        lineValid = 1'b1; lineBallId = 4'd1; lineVelocityX = 11'sd10; lineVelocityY = 11'sd20;
        hitValid = 1'b1; hitBallId = 4'd2; hitVelocityX = -11'sd30; hitVelocityY = 11'sd40;
        tick();
        idle_inputs();
        tick();
        chk("t2_first_src", writeSrcHit, 0);
        chk("t2_first_ball", writeBallId, 1);
        tick();
        chk("t2_second_we", writeEnable, 1);
        chk("t2_second_src", writeSrcHit, 1);
        chk("t2_second_vx", outVelocityX, -30);
        tick();

        measure_starve("starve_a");
        measure_starve("starve_b");

        // Lock held: fill hit FIFO, fifth request waits, then drain in order.
        updateLock = 1'b1;
        hitValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hitBallId = 4'(10 + i); hitVelocityX = 11'(i); hitVelocityY = 11'(-i);
            tick();
        end
        chk("lock_hit_ready_full", hitReady, 0);
        chk("lock_no_write", writeEnable, 0);
        hitBallId = 4'd14; hitVelocityX = 11'sd4; hitVelocityY = -11'sd4;
        tick();
        tick();
        chk("lock_fifth_held", hitReady, 0);
        updateLock = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && n < 5; i++) begin
            acc = hitValid && hitReady;
            tick();
            if (acc) hitValid = 1'b0;
            if (writeEnable) begin
                chk($sformatf("lock_drain_id%0d", n), writeBallId, 10 + n);
                n++;
            end
        end
        chk("lock_drain_count", n, 5);
        idle_inputs();
        repeat (3) tick();

        // Saturation of out-of-range components.
        lineValid = 1'b1; lineBallId = 4'd7; lineVelocityX = 11'sd700; lineVelocityY = -11'sd1024;
        tick();
        lineValid = 1'b0;
        tick();
        chk("sat_we", writeEnable, 1);
`ifdef VELOCITY_ARB_SATURATE_EN
        chk("sat_vx", outVelocityX, 511);
        chk("sat_vy", outVelocityY, -511);
        chk("sat_flag", writeSat, 1);
`else
        chk("sat_vx", outVelocityX, 700);
        chk("sat_vy", outVelocityY, -1024);
        chk("sat_flag", writeSat, 0);
`endif
        tick();

        // Reset with three queued line requests: they are lost.
        updateLock = 1'b1;
        lineValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lineBallId = 4'(4 + i); lineVelocityX = 11'(20 * i); lineVelocityY = 11'sd1;
            tick();
        end
        lineValid = 1'b0;
        pulse_reset("mid_reset");
        nw = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (writeEnable) nw++;
        end
        chk("mid_reset_no_writes", nw, 0);

        // Randomized traffic: heavy lock first to exercise full FIFOs, then light lock.
        for (int c = 0; c < 3000; c++) begin
            rand_inputs(c < 1500 ? 35 : 5);
            if ($urandom_range(0, 699) == 0) pulse_reset("rand_reset");
            tick();
        end
        idle_inputs();
        repeat (12) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
